dm_access_unit: RTL

- Parametrised, multi-cycle data-memory access unit for the M stage; successor to the combinational store byte-enable/data-alignment logic.
- Accepts one load/store request at a time and aligns store data to a byte-lane enable mask.
- Drives a memory port with a req/ack handshake and a timeout, then returns the load result extracted and sign- or zero-extended.
- Flags misaligned, unsupported-size and timeout errors so the pipeline can stall and raise AdEL/AdES.

---
 rtl/dm_access_unit.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/dm_access_unit.sv
// M-stage data-memory access unit: aligns stores to byte lanes, runs a req/ack
// memory transaction with timeout, and returns extended load data or an error code.
module dm_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic [1:0]            resp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_byteen,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d, we_q, we_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic [1:0]          resp_err_q, resp_err_d;
  logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [BYTES-1:0]    mem_byteen_q, mem_byteen_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  // Request decode
  logic [3:0]          size_bytes;
  logic [OFF_W-1:0]    off;
  logic                size_bad, misal;
  logic [BYTES-1:0]    lanes, st_byteen;
  logic [DATA_W-1:0]   wdata_m, st_wdata;

  assign size_bytes = 4'd1 << req_size;
  assign off        = req_addr[OFF_W-1:0];
  assign size_bad   = {28'd0, size_bytes} > BYTES;
  assign misal      = (off & OFF_W'(size_bytes - 4'd1)) != '0;

  always_comb begin
    lanes   = '0;
    wdata_m = '0;
    for (int i = 0; i < BYTES; i++)
      if (i < int'(size_bytes)) lanes[i] = 1'b1;
    for (int i = 0; i < DATA_W; i++)
      if (i < (8 << req_size)) wdata_m[i] = req_wdata[i];
  end

  assign st_byteen = lanes << off;
  assign st_wdata  = wdata_m << {off, 3'b000};

  // Load lane extraction and sign/zero extension
  logic [DATA_W-1:0] ld_lane, ld_ext;
  logic              ld_sign;

  assign ld_lane = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_sign = 1'b0;
    ld_ext  = ld_lane;
    for (int i = 0; i < DATA_W; i++)
      if (i == (8 << size_q) - 1) ld_sign = ld_lane[i];
    for (int i = 0; i < DATA_W; i++)
      if (i >= (8 << size_q)) ld_ext[i] = ~uns_q & ld_sign;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    we_d         = we_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_byteen_d = mem_byteen_q;
    mem_wdata_d  = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        req_ready_d  = 1'b1;
        resp_rdata_d = '0;
        resp_err_d   = 2'd0;
        if (req_valid) begin
          req_ready_d = 1'b0;
          off_d       = off;
          size_d      = req_size;
          uns_d       = req_unsigned;
          we_d        = req_we;
          if (size_bad) begin
            resp_err_d   = 2'd2;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else if (misal) begin
            resp_err_d   = 2'd1;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else begin
            mem_req_d    = 1'b1;
            mem_we_d     = req_we;
            mem_addr_d   = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_byteen_d = req_we ? st_byteen : '0;
            mem_wdata_d  = st_wdata;
            cnt_d        = '0;
            state_d      = MEM;
          end
        end
      end
      MEM: begin
        // Ack takes priority over a timeout on the same cycle
        if (mem_ack) begin
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_byteen_d = '0;
          resp_rdata_d = we_q ? '0 : ld_ext;
          resp_err_d   = 2'd0;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_byteen_d = '0;
          resp_rdata_d = '0;
          resp_err_d   = 2'd3;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        req_ready_d  = 1'b1;
        resp_rdata_d = '0;
        resp_err_d   = 2'd0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      off_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      we_q         <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_byteen_q <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      we_q         <= we_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_byteen_q <= mem_byteen_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_byteen = mem_byteen_q;
  assign mem_wdata  = mem_wdata_q;
endmodule
